// File: rtl/sprite_sched_pkg.sv
// ============================================================================
// sprite_sched_pkg : shared types and constants for the sprite line scheduler
// Revision: 1.0
// ============================================================================
`default_nettype none

package sprite_sched_pkg;

   localparam int          SPRITE_DIM     = 8;
   localparam logic [11:0] LB_TRANSPARENT = 12'h000;

   // Field order mirrors the 37-bit host write word, MSB first.
   typedef struct packed {
      logic       en;
      logic [3:0] id;
      logic [7:0] palette;
      logic [3:0] color_sel;
      logic [9:0] x;
      logic [9:0] y;
   } sprite_attr_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      SCAN  = 3'd2,
      FETCH = 3'd3,
      WAIT  = 3'd4,
      DRAW  = 3'd5,
      DONE  = 3'd6
   } state_t;

endpackage

`default_nettype wire

// File: rtl/sprite_attr_table.sv
// ============================================================================
// sprite_attr_table : sprite attribute register file, one write / one read port
// Revision: 1.0
// ============================================================================
`default_nettype none

module sprite_attr_table
   import sprite_sched_pkg::*;
#(
   parameter int NUM_SPRITES = 16,
   localparam int IDX_W      = $clog2(NUM_SPRITES)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             we_i,
   input  logic [IDX_W-1:0] waddr_i,
   input  sprite_attr_t     wdata_i,
   input  logic [IDX_W-1:0] raddr_i,
   output sprite_attr_t     rdata_o
);

   sprite_attr_t entry_q [NUM_SPRITES];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_SPRITES; i++) entry_q[i] <= '0;
      end else if (we_i) begin
         entry_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = entry_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/sprite_line_scheduler.sv
// ============================================================================
// sprite_line_scheduler : clears a line buffer, then draws every sprite row
// covering the requested scanline via the pattern ROM.  Revision: 1.0
// ============================================================================
`default_nettype none

module sprite_line_scheduler
   import sprite_sched_pkg::*;
#(
   parameter int NUM_SPRITES = 16,
   parameter int H_RES       = 640,
   parameter int X_W         = 10,
   parameter int ROM_LAT     = 1,
   localparam int IDX_W      = $clog2(NUM_SPRITES),
   localparam int CNT_W      = $clog2(H_RES)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             tbl_we,
   input  logic [IDX_W-1:0] tbl_addr,
   input  logic [36:0]      tbl_data,
   input  logic             line_start,
   input  logic [X_W-1:0]   line_y,
   output logic [3:0]       rom_sprite_id,
   output logic [3:0]       rom_line,
   input  logic [7:0]       rom_pattern,
   output logic             lb_we,
   output logic [X_W-1:0]   lb_addr,
   output logic [11:0]      lb_data,
   output logic             busy,
   output logic             line_done,
   output logic             overrun
);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [X_W-1:0]   cur_y_q, cur_y_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [X_W-1:0]   x_q, x_d;
   logic [11:0]      color_q, color_d;
   logic [7:0]       pat_q, pat_d;
   logic [3:0]       rom_id_q, rom_id_d;
   logic [3:0]       rom_line_q, rom_line_d;
   logic             overrun_q;

   sprite_attr_t     rd_entry;
   logic [X_W-1:0]   dy;
   logic [X_W:0]     px;
   logic             last_idx;

   sprite_attr_table #(.NUM_SPRITES(NUM_SPRITES)) u_table (
      .clk     (clk),
      .reset_n (reset_n),
      .we_i    (tbl_we),
      .waddr_i (tbl_addr),
      .wdata_i (tbl_data),
      .raddr_i (idx_q),
      .rdata_o (rd_entry)
   );

   // Unsigned difference: sprites starting below the scanline wrap to a large dy.
   assign dy       = cur_y_q - rd_entry.y;
   assign px       = {1'b0, x_q} + (X_W+1)'(cnt_q[2:0]);
   assign last_idx = (idx_q == IDX_W'(NUM_SPRITES - 1));

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      cur_y_d    = cur_y_q;
      cnt_d      = cnt_q;
      x_d        = x_q;
      color_d    = color_q;
      pat_d      = pat_q;
      rom_id_d   = rom_id_q;
      rom_line_d = rom_line_q;
      lb_we      = 1'b0;
      lb_addr    = '0;
      lb_data    = LB_TRANSPARENT;
      line_done  = 1'b0;

      case (state_q)
         IDLE: begin
            if (line_start) begin
               cur_y_d = line_y;
               idx_d   = '0;
               cnt_d   = '0;
               state_d = CLEAR;
            end
         end
         CLEAR: begin
            lb_we   = 1'b1;
            lb_addr = X_W'(cnt_q);
            if (cnt_q == CNT_W'(H_RES - 1)) begin
               cnt_d   = '0;
               state_d = SCAN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         SCAN: begin
            if (rd_entry.en && (dy < X_W'(SPRITE_DIM))) begin
               x_d        = rd_entry.x;
               color_d    = {rd_entry.palette, rd_entry.color_sel};
               rom_id_d   = rd_entry.id;
               rom_line_d = {1'b0, dy[2:0]};
               state_d    = FETCH;
            end else if (last_idx) begin
               state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         FETCH: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (cnt_q == CNT_W'(ROM_LAT - 1)) begin
               pat_d   = rom_pattern;
               cnt_d   = '0;
               state_d = DRAW;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DRAW: begin
            if (pat_q[3'd7 - cnt_q[2:0]] && (px < (X_W+1)'(H_RES))) begin
               lb_we   = 1'b1;
               lb_addr = px[X_W-1:0];
               lb_data = color_q;
            end
            if (cnt_q[2:0] == 3'd7) begin
               cnt_d = '0;
               if (last_idx) begin
                  state_d = DONE;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = SCAN;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            line_done = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         cur_y_q    <= '0;
         cnt_q      <= '0;
         x_q        <= '0;
         color_q    <= '0;
         pat_q      <= '0;
         rom_id_q   <= '0;
         rom_line_q <= '0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cur_y_q    <= cur_y_d;
         cnt_q      <= cnt_d;
         x_q        <= x_d;
         color_q    <= color_d;
         pat_q      <= pat_d;
         rom_id_q   <= rom_id_d;
         rom_line_q <= rom_line_d;
         overrun_q  <= line_start && (state_q != IDLE);
      end
   end

   assign busy          = (state_q != IDLE);
   assign overrun       = overrun_q;
   assign rom_sprite_id = rom_id_q;
   assign rom_line      = rom_line_q;

endmodule

`default_nettype wire

// File: tb/tb_sprite_line_scheduler.sv
// ============================================================================
// tb_sprite_line_scheduler : directed self-checking bench for the scheduler
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sprite_line_scheduler;

   localparam int HR = 640;

   logic        clk = 1'b0;
   logic        reset_n, tbl_we, line_start;
   logic [3:0]  tbl_addr;
   logic [36:0] tbl_data;
   logic [9:0]  line_y;
   logic [3:0]  rom_sprite_id, rom_line;
   logic [7:0]  rom_pattern = 8'h00;
   logic [7:0]  tb_pat;
   logic        lb_we, busy, line_done, overrun;
   logic [9:0]  lb_addr;
   logic [11:0] lb_data;

   logic [11:0] lb [HR];
   int n_chk = 0, n_fail = 0;
   int done_cyc, n_wr, n_nz;

   always #5 clk = ~clk;

   // Pattern ROM stand-in with one registered cycle of latency.
   always @(posedge clk) rom_pattern <= tb_pat;

   sprite_line_scheduler dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .tbl_we        (tbl_we),
      .tbl_addr      (tbl_addr),
      .tbl_data      (tbl_data),
      .line_start    (line_start),
      .line_y        (line_y),
      .rom_sprite_id (rom_sprite_id),
      .rom_line      (rom_line),
      .rom_pattern   (rom_pattern),
      .lb_we         (lb_we),
      .lb_addr       (lb_addr),
      .lb_data       (lb_data),
      .busy          (busy),
      .line_done     (line_done),
      .overrun       (overrun)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wr_entry(input logic [3:0] a, input logic en, input logic [3:0] id,
                           input logic [7:0] pal, input logic [3:0] sel,
                           input logic [9:0] x, input logic [9:0] y);
      @(negedge clk);
      tbl_we   = 1'b1;
      tbl_addr = a;
      tbl_data = {en, id, pal, sel, x, y};
      @(negedge clk);
      tbl_we   = 1'b0;
   endtask

   // Cycle 0 is the cycle in which line_start is sampled.
   task automatic run_line(input logic [9:0] y, input int ovr_cyc, input int rst_cyc);
      int cyc;
      logic seen_done;
      for (int i = 0; i < HR; i++) lb[i] = 12'hFFF;
      done_cyc = -1; n_wr = 0; n_nz = 0; cyc = 0;
      @(negedge clk);
      line_start = 1'b1;
      line_y     = y;
      while (cyc < 3000) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) line_start = 1'b0;
         if (ovr_cyc > 0 && cyc == ovr_cyc) begin
            line_start = 1'b1;
            line_y     = 10'd0;
         end
         if (ovr_cyc > 0 && cyc == ovr_cyc + 1) begin
            chk("overrun_pulse", 32'(overrun), 32'd1);
            line_start = 1'b0;
         end
         if (rst_cyc > 0 && cyc == rst_cyc) begin
            reset_n = 1'b0;
            #1;
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_lb_we", 32'(lb_we), 32'd0);
            chk("rst_rom_line", 32'(rom_line), 32'd0);
            seen_done = 1'b0;
            repeat (5) begin
               @(negedge clk);
               seen_done = seen_done | line_done;
            end
            reset_n = 1'b1;
            chk("rst_no_done", 32'(seen_done), 32'd0);
            return;
         end
         if (lb_we) begin
            n_wr++;
            if (lb_data != 12'h000) n_nz++;
            if (lb_addr < 10'(HR)) lb[lb_addr] = lb_data;
         end
         if (line_done) begin
            done_cyc = cyc;
            break;
         end
      end
      if (done_cyc < 0) chk("line_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      int bad;
      reset_n = 1'b0; tbl_we = 1'b0; tbl_addr = '0; tbl_data = '0;
      line_start = 1'b0; line_y = '0; tb_pat = 8'h00;
      repeat (3) @(negedge clk);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_lb_we", 32'(lb_we), 32'd0);
      chk("reset_outputs", {lb_addr, lb_data, rom_sprite_id, rom_line, line_done, overrun},
          32'd0);
      reset_n = 1'b1;

      // Empty table: clear only.
      run_line(10'd100, 0, 0);
      chk("empty_done_cyc", 32'(done_cyc), 32'd657);
      chk("empty_writes", 32'(n_wr), 32'd640);
      bad = 0;
      for (int i = 0; i < HR; i++) if (lb[i] != 12'h000) bad++;
      chk("empty_clear_all", 32'(bad), 32'd0);

      // Single full-row sprite.
      tb_pat = 8'hFF;
      wr_entry(4'd0, 1'b1, 4'd4, 8'd1, 4'd3, 10'd20, 10'd96);
      run_line(10'd100, 0, 0);
      chk("single_done_cyc", 32'(done_cyc), 32'd667);
      chk("single_rom_line", 32'(rom_line), 32'd4);
      chk("single_rom_id", 32'(rom_sprite_id), 32'd4);
      chk("single_nz", 32'(n_nz), 32'd8);
      bad = 0;
      for (int i = 20; i < 28; i++) if (lb[i] != 12'h013) bad++;
      chk("single_pixels", 32'(bad), 32'd0);
      chk("single_left", 32'(lb[19]), 32'h000);
      chk("single_right", 32'(lb[28]), 32'h000);

      // Right-edge clipping, no wrap.
      wr_entry(4'd0, 1'b1, 4'd4, 8'd1, 4'd3, 10'd636, 10'd96);
      run_line(10'd100, 0, 0);
      chk("clip_nz", 32'(n_nz), 32'd4);
      chk("clip_636", 32'(lb[636]), 32'h013);
      chk("clip_639", 32'(lb[639]), 32'h013);
      bad = 0;
      for (int i = 0; i < 4; i++) if (lb[i] != 12'h000) bad++;
      chk("clip_no_wrap", 32'(bad), 32'd0);

      // Two sprites, half patterns, then overlapping.
      tb_pat = 8'hF0;
      wr_entry(4'd0, 1'b0, 4'd0, 8'd0, 4'd0, 10'd0, 10'd0);
      wr_entry(4'd2, 1'b1, 4'd1, 8'd1, 4'd1, 10'd10, 10'd100);
      wr_entry(4'd5, 1'b1, 4'd2, 8'd2, 4'd5, 10'd14, 10'd100);
      run_line(10'd100, 0, 0);
      chk("two_done_cyc", 32'(done_cyc), 32'd677);
      chk("two_nz", 32'(n_nz), 32'd8);
      chk("two_a10", 32'(lb[10]), 32'h011);
      chk("two_a13", 32'(lb[13]), 32'h011);
      chk("two_a14", 32'(lb[14]), 32'h025);
      chk("two_a17", 32'(lb[17]), 32'h025);
      chk("two_a18", 32'(lb[18]), 32'h000);
      wr_entry(4'd5, 1'b1, 4'd2, 8'd2, 4'd5, 10'd10, 10'd100);
      run_line(10'd100, 0, 0);
      chk("ovl_a10", 32'(lb[10]), 32'h025);
      chk("ovl_a13", 32'(lb[13]), 32'h025);
      chk("ovl_a14", 32'(lb[14]), 32'h000);

      // Vertical window edges.
      tb_pat = 8'hFF;
      wr_entry(4'd2, 1'b0, 4'd0, 8'd0, 4'd0, 10'd0, 10'd0);
      wr_entry(4'd5, 1'b0, 4'd0, 8'd0, 4'd0, 10'd0, 10'd0);
      wr_entry(4'd0, 1'b1, 4'd4, 8'd1, 4'd3, 10'd20, 10'd98);
      run_line(10'd97, 0, 0);
      chk("above_done_cyc", 32'(done_cyc), 32'd657);
      chk("above_nz", 32'(n_nz), 32'd0);
      run_line(10'd106, 0, 0);
      chk("below_done_cyc", 32'(done_cyc), 32'd657);
      run_line(10'd105, 0, 0);
      chk("last_row_done_cyc", 32'(done_cyc), 32'd667);
      chk("last_row_rom_line", 32'(rom_line), 32'd7);

      // line_start while clearing: flagged, line unaffected.
      run_line(10'd105, 5, 0);
      chk("ovr_done_cyc", 32'(done_cyc), 32'd667);
      chk("ovr_rom_line", 32'(rom_line), 32'd7);
      chk("ovr_pixel", 32'(lb[20]), 32'h013);

      // Reset in the middle of DRAW, then the table must be empty.
      run_line(10'd105, 0, 646);
      run_line(10'd105, 0, 0);
      chk("post_rst_done_cyc", 32'(done_cyc), 32'd657);
      chk("post_rst_nz", 32'(n_nz), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/sprite_line_scheduler.md
Name: sprite_line_scheduler

Overview:
- Per-scanline sequencer for the 8x8 sprite bit-pattern ROM (sprite_id/line in, 8-bit row out, 1-cycle registered latency).
- Holds a host-written sprite attribute table, clears a line buffer, then walks the table.
- For each sprite covering the requested scanline, fetches its ROM row and writes the set pixels into the line buffer as {palette, color_selection} indices, which the colour decoder resolves downstream.

Parameters:
- NUM_SPRITES, 16, attribute table entries; power of two.
- H_RES, 640, line buffer width in pixels.
- X_W, 10, x/y coordinate width.
- ROM_LAT, 1, cycles from ROM address to valid rom_pattern.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- tbl_we  in  1  attribute table write strobe.
- tbl_addr  in  $clog2(NUM_SPRITES)  entry index.
- tbl_data  in  37  {en[36], id[35:32], palette[31:24], color_sel[23:20], x[19:10], y[9:0]}.
- line_start  in  1  single-cycle request to build line line_y.
- line_y  in  X_W  scanline to build; sampled with line_start.
- rom_sprite_id  out  4  to pattern ROM.
- rom_line  out  4  to pattern ROM.
- rom_pattern  in  8  ROM row; bit 7 = leftmost pixel.
- lb_we  out  1  line buffer write enable.
- lb_addr  out  X_W  line buffer pixel address.
- lb_data  out  12  {palette, color_sel}; 0 = transparent.
- busy  out  1  high whenever state != IDLE.
- line_done  out  1  one-cycle pulse when the line is complete.
- overrun  out  1  one-cycle pulse when line_start arrives while busy.

Behaviour:
- Reset: state IDLE; table cleared, all en=0; every output 0.
- Table write: tbl_we writes the entry at the clock edge; it is accepted in any state. An entry is sampled by the scheduler only during its SCAN cycle, so a write landing earlier in the same line takes effect for that line.
- IDLE: line_start=1 latches line_y into cur_y, clears idx, goes to CLEAR.
- line_start while busy: ignored, with no effect on the line in progress; overrun pulses the next cycle.
- CLEAR: one pixel per cycle.
  - lb_we=1, lb_addr=0..H_RES-1, lb_data=0.
  - After H_RES cycles, go to SCAN.
- SCAN (1 cycle per entry): read entry[idx] and compute dy = cur_y - y, unsigned, X_W bits.
  - Hit when en=1 and dy<8: go to FETCH, latch the entry and dy[2:0].
  - Miss: idx++; after the last index go to DONE.
  - y>cur_y wraps to a large dy, which is a miss.
- FETCH (1 cycle): rom_sprite_id=id, rom_line={1'b0,dy[2:0]}. Go to WAIT.
- WAIT (ROM_LAT cycles): hold the ROM address. In the last WAIT cycle, capture rom_pattern into pat.
- DRAW (8 cycles, i=0..7):
  - Write when pat[7-i]=1 and x+i<H_RES: lb_we=1, lb_addr=x+i, lb_data={palette,color_sel}.
  - Otherwise lb_we=0.
  - Compute x+i at X_W+1 bits; never wrap to the left edge.
  - Then idx++ and go to SCAN, or to DONE after the last index.
- DONE (1 cycle): line_done=1, go to IDLE.
- Priority: higher index writes later and overwrites lower index. Zero pattern bits never overwrite.
- Timing: with line_start sampled in cycle 0, line_done is high in cycle H_RES+NUM_SPRITES+1+hits*(1+ROM_LAT+8).
- ROM outputs hold their last value outside FETCH/WAIT. lb_addr and lb_data are don't-care when lb_we=0 but are driven to 0.
- reset_n asserted mid-line: immediate return to IDLE, table cleared, outputs 0, no line_done.

Decomposition:
- Package sprite_sched_pkg:
  - sprite_attr_t packed struct matching the tbl_data layout.
  - state_t enum {IDLE, CLEAR, SCAN, FETCH, WAIT, DRAW, DONE}.
  - SPRITE_DIM=8, LB_TRANSPARENT=12'h000.
- Sub-module sprite_attr_table: NUM_SPRITES x sprite_attr_t register file, async-reset, one write port, one combinational read port indexed by idx.

Test Plan:
- All entries disabled; line_start with line_y=100 -> 640 clear writes of 0, no other lb_we, line_done exactly in cycle 657.
- Entry 0 = {en=1, id=4, pal=1, sel=3, x=20, y=96}, ROM returns 8'hFF, line_y=100 -> rom_line=4; writes addr 20..27 data 12'h013; line_done at cycle 667.
- Entry 0 at x=636 with pattern 8'hFF -> writes only 636..639; no write at addr 0..3.
- Entry 2 at x=10 (pal 1, sel 1) and entry 5 at x=14 (pal 2, sel 5), both pattern 8'hF0 -> addr 10..13 = 12'h011 and 14..17 = 12'h025. Overlap variant with both at x=10: final data at 10..13 is 12'h025.
- Sprite y=98 with line_y=97 and line_y=106 -> both misses; y=98 with line_y=105 -> hit with rom_line=7.
- line_start during CLEAR -> overrun pulse, first line completes unchanged. reset_n low during DRAW -> busy=0, lb_we=0 immediately, no line_done.
